mandelbrot_scheduler: RTL
=========================

Name: mandelbrot_scheduler

Overview:
Frame-level controller for a bank of NUM_ITER iterator_loop engines rendering one Mandelbrot frame.
- Takes a viewport (top-left complex coordinate plus per-pixel step) and splits the screen into column-interleaved slices. Engine k renders columns k, k+N, k+2N, …
- Drives each engine's init/incr/limit configuration and its reset, then waits for every engine to report done.
- Round-robin arbitrates the engines' pixel-write requests onto the single VGA frame-buffer M10K write port, and measures render time in cycles.

Parameters:
NUM_ITER, 4, number of iterator engines; must divide SCREEN_W.
DW, 27, coordinate width; signed fixed point 4.23 (1.0 = 27'h0800000).
SCREEN_W, 640, pixels per row.
SCREEN_H, 480, rows per frame.
AW, 19, frame-buffer address width.
PW, 8, pixel data width.
CW, 32, cycle-counter width.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse that begins a frame; ignored unless IDLE.
view_x0  in  DW  real part of the top-left pixel.
view_y0  in  DW  imaginary part of the top-left pixel.
step  in  DW  per-pixel coordinate increment (signed).
it_init_x  out  NUM_ITER*DW  per-engine starting x; slice k = bits [k*DW +: DW].
it_init_y  out  DW  shared starting y.
it_x_incr  out  DW  shared x increment (NUM_ITER*step).
it_y_incr  out  DW  shared y increment (step).
it_x_limit  out  NUM_ITER*DW  per-engine last x.
it_y_limit  out  DW  shared last y.
it_reset  out  NUM_ITER  active-high engine reset.
it_done  in  NUM_ITER  engine finished its slice (level).
it_wr_req  in  NUM_ITER  engine has a pixel to write; held until granted.
it_wr_addr  in  NUM_ITER*AW  per-engine pixel address.
it_wr_data  in  NUM_ITER*PW  per-engine iteration/colour value.
it_wr_grant  out  NUM_ITER  one-hot, combinational, same-cycle acknowledge.
mem_we  out  1  frame-buffer write enable.
mem_addr  out  AW  frame-buffer address.
mem_data  out  PW  frame-buffer data.
busy  out  1  high in every state other than IDLE.
frame_done  out  1  one-cycle pulse at end of frame.
cycle_count  out  CW  render cycles of the current or most recent frame.

Behaviour:
Reset values (reset low, asynchronous):
- state = IDLE; it_reset = all 1s; busy, frame_done, mem_we = 0.
- cycle_count = 0; rr_ptr = 0; done_mask = 0.
- All configuration registers = 0.

FSM: IDLE → LOAD → HOLD → RUN → FIN → IDLE.
- IDLE: engines held in reset. start=1 → LOAD next cycle.
- LOAD (1 cycle): register configuration. cycle_count cleared to 0.
  - init_x[k] = x0 + k*step
  - x_incr = NUM_ITER*step
  - x_limit[k] = x0 + (SCREEN_W−NUM_ITER+k)*step
  - init_y = y0
  - y_incr = step
  - y_limit = y0 + (SCREEN_H−1)*step
- Arithmetic: integer × step products and sums are DW-bit two's complement. Truncate to DW bits and wrap silently; no saturation.
- HOLD (2 cycles): it_reset stays 1 so engines sample the new configuration.
- RUN:
  - it_reset = 0.
  - done_mask[k] is set and stays set once it_done[k]=1.
  - Exit to FIN when done_mask is all 1s AND it_wr_req is all 0s AND no write is in flight on the mem_* register.
- FIN (1 cycle): frame_done=1, it_reset returns to all 1s, then IDLE.
- cycle_count increments every cycle in HOLD and RUN; it holds its value in FIN and IDLE until the next LOAD.

Write arbitration (all states):
- Grant goes to the first requester at or after rr_ptr, searching cyclically. At most one grant per cycle.
- On a grant to engine g: rr_ptr ← g+1 mod NUM_ITER.
- mem_we/mem_addr/mem_data are registered one cycle after the grant. mem_we=0 in any cycle after no grant.
- Requests in IDLE cannot occur because the engines are in reset.

Boundaries:
- start in any non-IDLE state: ignored, no effect.
- it_done and it_wr_req high in the same cycle: done is latched and the write is still served; FIN waits for it.
- All NUM_ITER requesting every cycle: each engine is granted exactly once per NUM_ITER cycles.
- Reset low mid-frame: immediate return to reset values; any in-flight mem write is dropped.
- cycle_count at max value: wraps.

Decomposition:
- Shared package: fixed-point constants (DW, FRAC=23, ONE=27'h0800000) and the state encoding.
- One sub-module, rr_arbiter: NUM_ITER requests, rotating pointer, one-hot grant plus encoded grant index.

Test Plan:
1. NUM_ITER=2, SCREEN_W=4, SCREEN_H=2; x0=27'h7000000 (−2.0), y0=27'h7800000 (−1.0), step=27'h0400000 (0.5); pulse start → in HOLD:
   - init_x = {27'h7400000, 27'h7000000}
   - x_incr = 27'h0800000
   - x_limit = {27'h7C00000, 27'h7800000}
   - y_limit = 27'h7C00000
   - it_reset high for exactly 2 cycles.
2. Engines assert it_done at RUN+5 and RUN+9 → frame_done pulses once, at RUN+10. cycle_count = 12 and holds through IDLE.
3. Both engines hold it_wr_req for 6 cycles → grants alternate 01,10,01… and mem_we is high 6 consecutive cycles with matching addr/data, each one cycle late.
4. Pulse start in RUN → no reconfiguration, no cycle_count clear.
5. Assert reset low in RUN → same cycle: it_reset=11, busy=0, mem_we=0. After release: IDLE, and a new start renders normally.
6. it_done[0] and it_wr_req[0] in the same final cycle → the write reaches mem_we before frame_done asserts.

Source files
------------

// File: rtl/mandelbrot_scheduler_pkg.sv
// Shared constants and state encoding for the Mandelbrot frame scheduler.
package mandelbrot_scheduler_pkg;

    // Signed 4.23 fixed point coordinates
    localparam int unsigned DW   = 27;
    localparam int unsigned FRAC = 23;
    localparam logic [DW-1:0] ONE = 27'h0800000;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHold,
        StRun,
        StFin
    } state_e;

endpackage

// File: rtl/mandelbrot_scheduler_if.sv
// Engine-side bus: per-engine configuration, engine resets, pixel-write
// requests and the frame-buffer write port.
interface mandelbrot_scheduler_if #(
    parameter int unsigned NUM_ITER = 4,
    parameter int unsigned DW       = 27,
    parameter int unsigned AW       = 19,
    parameter int unsigned PW       = 8
);

    logic [NUM_ITER*DW-1:0] it_init_x;
    logic [DW-1:0]          it_init_y;
    logic [DW-1:0]          it_x_incr;
    logic [DW-1:0]          it_y_incr;
    logic [NUM_ITER*DW-1:0] it_x_limit;
    logic [DW-1:0]          it_y_limit;
    logic [NUM_ITER-1:0]    it_reset;
    logic [NUM_ITER-1:0]    it_done;
    logic [NUM_ITER-1:0]    it_wr_req;
    logic [NUM_ITER*AW-1:0] it_wr_addr;
    logic [NUM_ITER*PW-1:0] it_wr_data;
    logic [NUM_ITER-1:0]    it_wr_grant;
    logic                   mem_we;
    logic [AW-1:0]          mem_addr;
    logic [PW-1:0]          mem_data;

    // Scheduler side
    modport master (
        output it_init_x, it_init_y, it_x_incr, it_y_incr, it_x_limit, it_y_limit,
        output it_reset, it_wr_grant, mem_we, mem_addr, mem_data,
        input  it_done, it_wr_req, it_wr_addr, it_wr_data
    );

    // Engines and frame buffer side
    modport slave (
        input  it_init_x, it_init_y, it_x_incr, it_y_incr, it_x_limit, it_y_limit,
        input  it_reset, it_wr_grant, mem_we, mem_addr, mem_data,
        output it_done, it_wr_req, it_wr_addr, it_wr_data
    );

endinterface

// File: rtl/mandelbrot_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer; the pointer moves just past the winner.
module mandelbrot_scheduler_rr_arbiter #(
    parameter int unsigned NUM_ITER = 4,
    parameter int unsigned IW       = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ITER-1:0] req,
    output logic [NUM_ITER-1:0] grant,
    output logic [IW-1:0]       grant_idx,
    output logic                grant_valid
);
    import mandelbrot_scheduler_pkg::*;

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    // Cyclic search starting at the pointer; first hit wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < int'(NUM_ITER); i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= int'(NUM_ITER)) begin
                idx = idx - int'(NUM_ITER);
            end
            if (!found && req[IW'(idx)]) begin
                found            = 1'b1;
                grant[IW'(idx)]  = 1'b1;
                grant_idx        = IW'(idx);
            end
        end
    end

    assign grant_valid = found;

    // Pointer advances to winner+1, wrapping at NUM_ITER
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (grant_idx == IW'(NUM_ITER - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mandelbrot_scheduler.sv
// Frame controller: configures a bank of iterator engines with
// column-interleaved slices of the viewport, runs them until all report done,
// funnels their pixel writes onto one frame-buffer port and times the frame.
module mandelbrot_scheduler #(
    parameter int unsigned NUM_ITER = 4,
    parameter int unsigned DW       = mandelbrot_scheduler_pkg::DW,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned AW       = 19,
    parameter int unsigned PW       = 8,
    parameter int unsigned CW       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DW-1:0]          view_x0,
    input  logic [DW-1:0]          view_y0,
    input  logic [DW-1:0]          step,
    mandelbrot_scheduler_if.master eng,
    output logic                   busy,
    output logic                   frame_done,
    output logic [CW-1:0]          cycle_count
);
    import mandelbrot_scheduler_pkg::*;

    localparam int unsigned IW = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

    state_e                 state_q, state_d;
    logic                   hold_cnt_q;
    logic [NUM_ITER-1:0]    done_mask_q;
    logic [CW-1:0]          cycle_q;

    logic [NUM_ITER*DW-1:0] init_x_q;
    logic [NUM_ITER*DW-1:0] x_limit_q;
    logic [DW-1:0]          init_y_q;
    logic [DW-1:0]          x_incr_q;
    logic [DW-1:0]          y_incr_q;
    logic [DW-1:0]          y_limit_q;

    logic [NUM_ITER-1:0]    grant;
    logic [IW-1:0]          grant_idx;
    logic                   grant_valid;
    logic [AW-1:0]          wr_addr;
    logic [PW-1:0]          wr_data;
    logic                   mem_we_q;
    logic [AW-1:0]          mem_addr_q;
    logic [PW-1:0]          mem_data_q;

    logic                   all_done;
    logic                   frame_clear;

    // A done seen this cycle counts immediately; the frame only closes once no
    // write is requested or still sitting on the memory port.
    assign all_done    = &(done_mask_q | eng.it_done);
    assign frame_clear = all_done && !(|eng.it_wr_req) && !mem_we_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StHold;
            StHold:  if (hold_cnt_q) state_d = StRun;
            StRun:   if (frame_clear) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        busy         = (state_q != StIdle);
        frame_done   = (state_q == StFin);
        eng.it_reset = (state_q == StRun) ? '0 : '1;
    end

    // State register and two-cycle HOLD counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            hold_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= (state_q == StHold) ? ~hold_cnt_q : 1'b0;
        end
    end

    // Sticky per-engine done flags, cleared when a frame is loaded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_mask_q <= '0;
        end else if (state_q == StLoad) begin
            done_mask_q <= '0;
        end else if (state_q == StRun) begin
            done_mask_q <= done_mask_q | eng.it_done;
        end
    end

    // Render timer: counts HOLD and RUN cycles, holds otherwise, wraps at max
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
        end else if (state_q == StLoad) begin
            cycle_q <= '0;
        end else if (state_q == StHold || state_q == StRun) begin
            cycle_q <= cycle_q + 1'b1;
        end
    end

    assign cycle_count = cycle_q;

    // Slice configuration: engine k owns columns k, k+N, ...; all sums wrap at DW bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_x_q  <= '0;
            x_limit_q <= '0;
            init_y_q  <= '0;
            x_incr_q  <= '0;
            y_incr_q  <= '0;
            y_limit_q <= '0;
        end else if (state_q == StLoad) begin
            for (int k = 0; k < int'(NUM_ITER); k++) begin
                init_x_q[k*DW +: DW]  <= view_x0 + DW'(k) * step;
                x_limit_q[k*DW +: DW] <= view_x0 + DW'(int'(SCREEN_W - NUM_ITER) + k) * step;
            end
            init_y_q  <= view_y0;
            x_incr_q  <= DW'(NUM_ITER) * step;
            y_incr_q  <= step;
            y_limit_q <= view_y0 + DW'(SCREEN_H - 1) * step;
        end
    end

    assign eng.it_init_x  = init_x_q;
    assign eng.it_x_limit = x_limit_q;
    assign eng.it_init_y  = init_y_q;
    assign eng.it_x_incr  = x_incr_q;
    assign eng.it_y_incr  = y_incr_q;
    assign eng.it_y_limit = y_limit_q;

    mandelbrot_scheduler_rr_arbiter #(
        .NUM_ITER (NUM_ITER),
        .IW       (IW)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (eng.it_wr_req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign eng.it_wr_grant = grant;

    // Select the granted engine's address and data
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        for (int k = 0; k < int'(NUM_ITER); k++) begin
            if (IW'(k) == grant_idx) begin
                wr_addr = eng.it_wr_addr[k*AW +: AW];
                wr_data = eng.it_wr_data[k*PW +: PW];
            end
        end
    end

    // Frame-buffer port, one cycle behind the grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            mem_we_q <= grant_valid;
            if (grant_valid) begin
                mem_addr_q <= wr_addr;
                mem_data_q <= wr_data;
            end
        end
    end

    assign eng.mem_we   = mem_we_q;
    assign eng.mem_addr = mem_addr_q;
    assign eng.mem_data = mem_data_q;

endmodule
